sub_bytes_engine: RTL and testbench
===================================

SUB_BYTES_ENGINE -- requirements
Module: sub_bytes_engine

Interface
REQ-001 SHALL have parameter NBYTES, default 4: bytes per word; legal values are 4 (key-expansion word) and 16 (full state).
REQ-002 SHALL have parameter LANES, default 1: number of S-box instances. LANES SHALL divide NBYTES.
REQ-003 SHALL have port clk, input, 1 bit: single clock, rising-edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1 bit: the source offers a word.
REQ-006 SHALL have port in_ready, output, 1 bit: the engine can accept a word.
REQ-007 SHALL have port in_data, input, 8*NBYTES bits: the word to substitute.
REQ-008 SHALL have port out_valid, output, 1 bit: the result is available.
REQ-009 SHALL have port out_ready, input, 1 bit: the sink accepts the result.
REQ-010 SHALL have port out_data, output, 8*NBYTES bits: the substituted word.
REQ-011 SHALL have port abort, input, 1 bit: synchronous cancel of any operation.
REQ-012 SHALL have port inv, input, 1 bit: select the inverse S-box. This port is present only under SUBBYTES_INV_EN (see REQ-029).

Function
REQ-013 SHALL implement an FSM with states IDLE, BUSY and DONE.
REQ-014 SHALL accept a word when in_valid && in_ready: in_data (and inv) are latched and the FSM moves to BUSY with beat counter = 0.
REQ-015 In BUSY, SHALL substitute LANES bytes per cycle, starting from the most significant group and moving down; the counter increments each cycle.
REQ-016 SHALL move from BUSY to DONE on the cycle the last group (counter = NBYTES/LANES-1) is written, so out_valid rises exactly NBYTES/LANES cycles after acceptance.
REQ-017 Each output byte SHALL equal the FIPS-197 S-box (or inverse S-box, REQ-029) of the byte at the same position; byte order SHALL be unchanged.
REQ-018 In DONE, out_valid=1 and out_data SHALL hold stable until out_valid && out_ready.
REQ-019 in_ready SHALL be 1 in IDLE, and 1 in DONE when out_ready=1 (back-to-back transfer); it SHALL be 0 otherwise.
REQ-020 A simultaneous output handshake and input accept in DONE SHALL go directly to BUSY with the new word; without a new accept the FSM SHALL return to IDLE.
REQ-021 in_ready and out_valid SHALL never both depend combinationally on in_valid; in_ready depends only on state and out_ready.
REQ-022 out_data SHALL be driven from a register; it SHALL retain the last result in IDLE and update only in BUSY.
REQ-023 abort=1 SHALL force IDLE on the next edge from any state and clear out_valid; abort has priority over every handshake in the same cycle.
REQ-024 With NBYTES=LANES, latency SHALL be 1 cycle.

Reset
REQ-025 While rst=1, SHALL asynchronously force: state=IDLE, counter=0, out_valid=0, in_ready=1, out_data=0.
REQ-026 A reset asserted mid-BUSY or in DONE SHALL discard the word; no partial result is ever flagged valid.
REQ-027 The first accept SHALL be possible on the first rising edge after rst deasserts.

Configuration
REQ-028 The macro SUBBYTES_INV_EN SHALL control inverse S-box support.
REQ-029 With SUBBYTES_INV_EN defined, port inv SHALL exist; inv is latched at accept and selects the inverse S-box for that whole word.
REQ-030 Without SUBBYTES_INV_EN, port inv and the inverse tables SHALL be absent and the engine is forward-only.

Verification
REQ-031 Word test (NBYTES=4, LANES=1): in_data=0xCF4F3C09 -> out_data=0x8A84EB01 with out_valid 4 cycles after accept.
REQ-032 Full state (NBYTES=16, LANES=4): in_data=0x00..00 -> out_data=0x6363..63 (16 bytes) after 4 cycles; in_data=0xFF..FF -> 0x1616..16.
REQ-033 Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_data stable, in_ready=0; then assert out_ready together with in_valid (data 0x53535353) -> goes straight to BUSY, result 0xEDEDEDED.
REQ-034 Reset/abort: assert rst at beat 2 of 4 -> out_valid=0 and out_data=0 immediately; abort in DONE -> IDLE next cycle with no handshake.
REQ-035 With SUBBYTES_INV_EN defined: inv=1, in_data=0x8A84EB01 -> 0xCF4F3C09; inv=1, 0x63636363 -> 0x00000000.

Source files
------------

// File: rtl/sub_bytes_engine.sv
// Purpose : AES SubBytes on an NBYTES-byte word, LANES S-box lookups per cycle.
// Latency : NBYTES/LANES cycles from accept to out_valid (1 when LANES == NBYTES).
// Backpressure: result held in DONE until out_ready; in_ready = IDLE | (DONE & out_ready).
//
// Ports:
//    clk, rst              rising-edge clock, asynchronous active-high reset
//    in_valid/in_ready     input word handshake, in_data = 8*NBYTES-bit word
//    out_valid/out_ready   result handshake, out_data = registered result word
//    abort                 synchronous cancel, wins over every handshake
//    inv                   inverse S-box select, latched at accept (SUBBYTES_INV_EN only)
// Build option: define SUBBYTES_INV_EN to add port inv and the inverse S-box table.
// Legal parameters: NBYTES in {4, 16}; LANES must divide NBYTES.

module sub_bytes_engine #(
   parameter int NBYTES = 4,
   parameter int LANES  = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [8*NBYTES-1:0] in_data,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [8*NBYTES-1:0] out_data,
   input  logic                abort
`ifdef SUBBYTES_INV_EN
   ,
   input  logic                inv
`endif
);

   localparam int BEATS = NBYTES / LANES;
   localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int GW    = 8 * LANES;
   localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

   // Forward S-box, entry 0x00 in the most significant byte.
   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] f_sbox(input logic [7:0] b);
      return SBOX[8*(255 - int'(b)) +: 8];
   endfunction

`ifdef SUBBYTES_INV_EN
   localparam logic [2047:0] INV_SBOX = {
      128'h52096ad53036a538bf40a39e81f3d7fb,
      128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e,
      128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692,
      128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506,
      128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673,
      128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b,
      128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f,
      128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961,
      128'h172b047eba77d626e169146355210c7d
   };

   function automatic logic [7:0] f_inv_sbox(input logic [7:0] b);
      return INV_SBOX[8*(255 - int'(b)) +: 8];
   endfunction
`endif

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t                r_state;
   state_t                w_next_state;
   logic [CW-1:0]         r_cnt;
   logic [8*NBYTES-1:0]   r_word;
   logic [8*NBYTES-1:0]   r_out;
   logic                  w_accept;
   logic                  w_last;
   int                    w_lsb;
   logic [GW-1:0]         w_grp_in;
   logic [GW-1:0]         w_grp_out;
`ifdef SUBBYTES_INV_EN
   logic                  r_inv;
`endif

   assign w_accept = in_valid & in_ready;
   assign w_last   = (r_cnt == LAST);
   assign out_data = r_out;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      w_next_state = r_state;
      if (abort) begin
         w_next_state = IDLE;
      end else begin
         case (r_state)
            IDLE: if (w_accept) w_next_state = BUSY;
            BUSY: if (w_last) w_next_state = DONE;
            DONE: begin
               // Output handshake; a simultaneous accept chains straight into BUSY.
               if (out_ready) w_next_state = w_accept ? BUSY : IDLE;
            end
            default: w_next_state = IDLE;
         endcase
      end
   end

   // ---------------- FSM: outputs ----------------
   // in_ready is a function of state and out_ready only, never of in_valid.
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (r_state)
         IDLE: in_ready = 1'b1;
         DONE: begin
            in_ready  = out_ready;
            out_valid = 1'b1;
         end
         default: ;
      endcase
   end

   // ---------------- datapath ----------------
   // Beat r_cnt works on byte group r_cnt counted from the most significant end.
   always_comb begin
      w_lsb     = 8*NBYTES - GW*(int'(r_cnt) + 1);
      w_grp_in  = r_word[w_lsb +: GW];
      w_grp_out = '0;
      for (int l = 0; l < LANES; l++) begin
`ifdef SUBBYTES_INV_EN
         w_grp_out[8*l +: 8] = r_inv ? f_inv_sbox(w_grp_in[8*l +: 8])
                                     : f_sbox(w_grp_in[8*l +: 8]);
`else
         w_grp_out[8*l +: 8] = f_sbox(w_grp_in[8*l +: 8]);
`endif
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt  <= '0;
         r_word <= '0;
         r_out  <= '0;
`ifdef SUBBYTES_INV_EN
         r_inv  <= 1'b0;
`endif
      end else if (abort) begin
         r_cnt <= '0;
      end else if (w_accept) begin
         // in_ready is low in BUSY, so an accept never collides with a beat.
         r_word <= in_data;
         r_cnt  <= '0;
`ifdef SUBBYTES_INV_EN
         r_inv  <= inv;
`endif
      end else if (r_state == BUSY) begin
         r_out[w_lsb +: GW] <= w_grp_out;
         r_cnt              <= w_last ? '0 : r_cnt + CW'(1);
      end
   end

endmodule

// File: tb/tb_sub_bytes_engine.sv
module tb_sub_bytes_engine;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;
   int   tests = 0;
   int   fails = 0;

   // DUT A: 4-byte word, 1 lane
   logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_abort;
   logic [31:0] a_in_data, a_out_data;
   // DUT B: 16-byte state, 4 lanes
   logic         b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_abort;
   logic [127:0] b_in_data, b_out_data;
   // DUT C: 4-byte word, 4 lanes (single-cycle)
   logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_abort;
   logic [31:0] c_in_data, c_out_data;
`ifdef SUBBYTES_INV_EN
   logic a_inv, b_inv, c_inv;
`endif

   sub_bytes_engine #(.NBYTES(4), .LANES(1)) u_a (
      .clk(clk), .rst(rst),
      .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
      .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
      .abort(a_abort)
`ifdef SUBBYTES_INV_EN
      , .inv(a_inv)
`endif
   );

   sub_bytes_engine #(.NBYTES(16), .LANES(4)) u_b (
      .clk(clk), .rst(rst),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
      .abort(b_abort)
`ifdef SUBBYTES_INV_EN
      , .inv(b_inv)
`endif
   );

   sub_bytes_engine #(.NBYTES(4), .LANES(4)) u_c (
      .clk(clk), .rst(rst),
      .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
      .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
      .abort(c_abort)
`ifdef SUBBYTES_INV_EN
      , .inv(c_inv)
`endif
   );

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Called at a negedge: offers one word to A, returns at the negedge after the accept edge.
   task automatic a_accept(input logic [31:0] d);
      a_in_valid = 1'b1;
      a_in_data  = d;
      @(posedge clk);
      @(negedge clk);
      a_in_valid = 1'b0;
   endtask

   // Starts at the negedge right after acceptance; out_valid must rise exactly 4 edges later.
   task automatic a_wait(input string tag, input logic [31:0] exp);
      for (int k = 0; k <= 4; k++) begin
         if (k > 0) @(negedge clk);
         check({tag, "_valid"}, 128'(a_out_valid), 128'(k == 4));
         if (k < 4) check({tag, "_busy_rdy"}, 128'(a_in_ready), 128'(0));
      end
      check({tag, "_data"}, 128'(a_out_data), 128'(exp));
   endtask

   task automatic b_run(input string tag, input logic [127:0] d, input logic [127:0] exp);
      b_in_valid  = 1'b1;
      b_in_data   = d;
      b_out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      b_in_valid = 1'b0;
      for (int k = 0; k <= 4; k++) begin
         if (k > 0) @(negedge clk);
         check({tag, "_valid"}, 128'(b_out_valid), 128'(k == 4));
      end
      check({tag, "_data"}, b_out_data, exp);
      @(negedge clk);
      check({tag, "_drained"}, 128'(b_out_valid), 128'(0));
   endtask

   task automatic c_run(input string tag, input logic [31:0] d, input logic [31:0] exp);
      c_in_valid  = 1'b1;
      c_in_data   = d;
      c_out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      c_in_valid = 1'b0;
      check({tag, "_valid0"}, 128'(c_out_valid), 128'(0));
      @(negedge clk);
      check({tag, "_valid1"}, 128'(c_out_valid), 128'(1));
      check({tag, "_data"}, 128'(c_out_data), 128'(exp));
      @(negedge clk);
      check({tag, "_drained"}, 128'(c_out_valid), 128'(0));
   endtask

   initial begin
      rst = 1'b1;
      a_in_valid = 0; a_in_data = '0; a_out_ready = 0; a_abort = 0;
      b_in_valid = 0; b_in_data = '0; b_out_ready = 0; b_abort = 0;
      c_in_valid = 0; c_in_data = '0; c_out_ready = 0; c_abort = 0;
`ifdef SUBBYTES_INV_EN
      a_inv = 0; b_inv = 0; c_inv = 0;
`endif
      repeat (2) @(negedge clk);
      check("rst_a_valid", 128'(a_out_valid), 128'(0));
      check("rst_a_ready", 128'(a_in_ready), 128'(1));
      check("rst_a_data", 128'(a_out_data), 128'(0));
      check("rst_b_ready", 128'(b_in_ready), 128'(1));
      check("rst_b_data", b_out_data, 128'(0));

      // Word offered in the same cycle reset is released: accepted on the first edge.
      rst = 1'b0;
      a_accept(32'hCF4F3C09);
      a_wait("word", 32'h8A84EB01);

      // Backpressure in DONE
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("bp_data", 128'(a_out_data), 128'(32'h8A84EB01));
         check("bp_valid", 128'(a_out_valid), 128'(1));
         check("bp_ready", 128'(a_in_ready), 128'(0));
      end

      // Output handshake and new accept in the same cycle
      a_out_ready = 1'b1;
      a_in_valid  = 1'b1;
      a_in_data   = 32'h53535353;
      #1;
      check("b2b_in_ready", 128'(a_in_ready), 128'(1));
      @(posedge clk);
      @(negedge clk);
      a_in_valid = 1'b0;
      check("b2b_in_busy", 128'(a_in_ready), 128'(0));
      a_wait("b2b", 32'hEDEDEDED);
      @(negedge clk);
      check("b2b_idle_valid", 128'(a_out_valid), 128'(0));
      check("b2b_idle_ready", 128'(a_in_ready), 128'(1));
      check("b2b_idle_hold", 128'(a_out_data), 128'(32'hEDEDEDED));

      // Reset during beat 2 of 4
      a_out_ready = 1'b0;
      a_accept(32'h00000000);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1;
      check("midrst_valid", 128'(a_out_valid), 128'(0));
      check("midrst_data", 128'(a_out_data), 128'(0));
      check("midrst_ready", 128'(a_in_ready), 128'(1));
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("midrst_novalid", 128'(a_out_valid), 128'(0));
      end

      // Abort in DONE beats a simultaneous output handshake and input accept
      a_accept(32'h01010101);
      a_wait("abort_word", 32'h7C7C7C7C);
      a_abort     = 1'b1;
      a_out_ready = 1'b1;
      a_in_valid  = 1'b1;
      a_in_data   = 32'hCF4F3C09;
      @(posedge clk);
      @(negedge clk);
      a_abort    = 1'b0;
      a_in_valid = 1'b0;
      check("abort_valid", 128'(a_out_valid), 128'(0));
      check("abort_idle", 128'(a_in_ready), 128'(1));
      check("abort_hold", 128'(a_out_data), 128'(32'h7C7C7C7C));
      a_out_ready = 1'b0;

`ifdef SUBBYTES_INV_EN
      // Inverse S-box; inv dropped right after accept to prove it is latched
      a_inv = 1'b1;
      a_accept(32'h8A84EB01);
      a_inv = 1'b0;
      a_wait("inv_word", 32'hCF4F3C09);
      a_out_ready = 1'b1;
      @(negedge clk);
      a_out_ready = 1'b0;
      a_inv = 1'b1;
      a_accept(32'h63636363);
      a_inv = 1'b0;
      a_wait("inv_63", 32'h00000000);
      a_out_ready = 1'b1;
      @(negedge clk);
      a_out_ready = 1'b0;
`endif

      // Full state, 4 lanes
      b_run("state_00", {16{8'h00}}, {16{8'h63}});
      b_run("state_ff", {16{8'hFF}}, {16{8'h16}});
      b_run("state_mix", {{12{8'h00}}, 32'hCF4F3C09}, {{12{8'h63}}, 32'h8A84EB01});

      // Single-cycle latency when every byte has its own lane
      c_run("lat1_word", 32'hCF4F3C09, 32'h8A84EB01);
      c_run("lat1_53", 32'h5353FF00, 32'hEDED1663);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
